// File: rtl/nibble_packer_if.sv
// Handshake bundle between the nibble source, the packer and the word consumer.
// master drives nibbles/flush/out_ready; slave is the packer itself.
interface nibble_packer_if #(
  parameter int unsigned NibWidth    = 4,
  parameter int unsigned NibsPerWord = 2,
  parameter int unsigned FifoDepth   = 4
);
  localparam int unsigned WordWidth = NibWidth * NibsPerWord;
  localparam int unsigned LvlWidth  = $clog2(FifoDepth) + 1;

  logic                 in_valid;
  logic [NibWidth-1:0]  in_data;
  logic                 in_ready;
  logic                 flush;
  logic                 out_valid;
  logic [WordWidth-1:0] out_data;
  logic                 out_partial;
  logic                 out_ready;
  logic [LvlWidth-1:0]  fifo_level;
  logic                 overflow_err;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_partial, fifo_level, overflow_err
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_partial, fifo_level, overflow_err
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs nibbles LSB-first into words and queues them in a small FIFO; a flush
// emits the zero-padded partial word, deferred while the FIFO is full.
module nibble_packer #(
  parameter int unsigned NibWidth    = 4,
  parameter int unsigned NibsPerWord = 2,
  parameter int unsigned FifoDepth   = 4
) (
  input logic             clk,
  input logic             rst,
  nibble_packer_if.slave  pk_io
);
  localparam int unsigned WordWidth = NibWidth * NibsPerWord;
  localparam int unsigned PtrWidth  = $clog2(FifoDepth);
  localparam int unsigned LvlWidth  = PtrWidth + 1;
  localparam int unsigned CntWidth  = $clog2(NibsPerWord);

  localparam logic [1:0] StEmpty     = 2'd0;
  localparam logic [1:0] StFill      = 2'd1;
  localparam logic [1:0] StFlushPend = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [WordWidth-1:0] acc_q, acc_d, acc_ins;
  logic [CntWidth-1:0]  cnt_q, cnt_d, cnt_ins;
  logic [WordWidth-1:0] mem_q [FifoDepth];
  logic                 part_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LvlWidth-1:0]  level_q, level_d;
  logic                 ovf_q;

  logic full, in_ready, accept, pop, word_done, has_nib;
  logic push, push_part;

  assign full      = (level_q == LvlWidth'(FifoDepth));
  assign in_ready  = !full && (state_q != StFlushPend);
  assign accept    = pk_io.in_valid && in_ready;
  assign pop       = (level_q != '0) && pk_io.out_ready;
  assign word_done = accept && (cnt_q == CntWidth'(NibsPerWord - 1));
  assign cnt_ins   = cnt_q + CntWidth'(accept);
  assign has_nib   = (cnt_ins != '0);

  always_comb begin
    acc_ins = acc_q;
    if (accept) begin
      acc_ins[cnt_q * NibWidth +: NibWidth] = pk_io.in_data;
    end
  end

  // The accepted nibble is merged before flush is considered, so a flush that
  // coincides with the completing nibble yields just the full word.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_ins;
    cnt_d     = cnt_ins;
    push      = 1'b0;
    push_part = 1'b0;
    if (word_done) begin
      push    = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = StEmpty;
    end else if (state_q == StFlushPend) begin
      if (!full) begin
        push      = 1'b1;
        push_part = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = StEmpty;
      end
    end else if (pk_io.flush && has_nib) begin
      if (!full) begin
        push      = 1'b1;
        push_part = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = StEmpty;
      end else begin
        state_d = StFlushPend;
      end
    end else begin
      state_d = has_nib ? StFill : StEmpty;
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LvlWidth'(1);
      2'b01:   level_d = level_q - LvlWidth'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StEmpty;
      acc_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i]  <= '0;
        part_q[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ovf_q   <= ovf_q | (pk_io.in_valid & ~in_ready);
      if (push) begin
        mem_q[wr_ptr_q]  <= acc_ins;
        part_q[wr_ptr_q] <= push_part;
        wr_ptr_q         <= wr_ptr_q + PtrWidth'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
      end
    end
  end

  assign pk_io.in_ready     = in_ready;
  assign pk_io.out_valid    = (level_q != '0);
  assign pk_io.out_data     = mem_q[rd_ptr_q];
  assign pk_io.out_partial  = part_q[rd_ptr_q];
  assign pk_io.fifo_level   = level_q;
  assign pk_io.overflow_err = ovf_q;
endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer: a nibble-list reference model queues
// expected words; an independent monitor checks every popped word.
module tb_nibble_packer;
  localparam int unsigned NibWidth    = 4;
  localparam int unsigned NibsPerWord = 2;
  localparam int unsigned FifoDepth   = 4;
  localparam int unsigned WordWidth   = NibWidth * NibsPerWord;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nibble_packer_if #(
    .NibWidth(NibWidth), .NibsPerWord(NibsPerWord), .FifoDepth(FifoDepth)
  ) pk_if ();

  nibble_packer #(
    .NibWidth(NibWidth), .NibsPerWord(NibsPerWord), .FifoDepth(FifoDepth)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pk_io (pk_if)
  );

  typedef struct packed {
    logic                 partial;
    logic [WordWidth-1:0] data;
  } word_t;

  int n_checks = 0;
  int n_fail   = 0;

  word_t               exp_q[$];
  logic [NibWidth-1:0] nibs_m[$];
  int                  lvl_m  = 0;
  bit                  pend_m = 1'b0;
  bit                  ovf_m  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Turns whatever nibbles are held into one word, zero-padding the top.
  task automatic emit(input bit partial);
    word_t w;
    w.data    = '0;
    w.partial = partial;
    for (int k = 0; k < nibs_m.size(); k++) begin
      w.data[k*NibWidth +: NibWidth] = nibs_m[k];
    end
    exp_q.push_back(w);
    nibs_m.delete();
    lvl_m++;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic cycle(input bit v, input logic [NibWidth-1:0] d, input bit f, input bit r);
    bit rdy, pop;
    rdy = (lvl_m < FifoDepth) && !pend_m;
    check("fifo_level", 32'(pk_if.fifo_level), lvl_m);
    check("in_ready", 32'(pk_if.in_ready), 32'(rdy));
    check("out_valid", 32'(pk_if.out_valid), 32'(lvl_m != 0));
    check("overflow_err", 32'(pk_if.overflow_err), 32'(ovf_m));
    pk_if.in_valid  = v;
    pk_if.in_data   = d;
    pk_if.flush     = f;
    pk_if.out_ready = r;
    pop = (lvl_m > 0) && r;
    if (v && !rdy) ovf_m = 1'b1;
    if (v && rdy) nibs_m.push_back(d);
    if (nibs_m.size() == NibsPerWord) begin
      emit(1'b0);
    end else if (pend_m) begin
      if (lvl_m < FifoDepth) begin
        emit(1'b1);
        pend_m = 1'b0;
      end
    end else if (f && nibs_m.size() > 0) begin
      if (lvl_m < FifoDepth) emit(1'b1);
      else pend_m = 1'b1;
    end
    if (pop) lvl_m--;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    pk_if.in_valid  = 1'b0;
    pk_if.in_data   = '0;
    pk_if.flush     = 1'b0;
    pk_if.out_ready = 1'b0;
    exp_q.delete();
    nibs_m.delete();
    lvl_m  = 0;
    pend_m = 1'b0;
    ovf_m  = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_out_valid", 32'(pk_if.out_valid), 0);
    check("rst_fifo_level", 32'(pk_if.fifo_level), 0);
    check("rst_in_ready", 32'(pk_if.in_ready), 1);
    check("rst_overflow_err", 32'(pk_if.overflow_err), 0);
    check("rst_out_data", 32'(pk_if.out_data), 0);
    check("rst_out_partial", 32'(pk_if.out_partial), 0);
    rst = 1'b1;
  endtask

  // Monitor: compares every handshaked head word against the scoreboard.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      #2;
      if (rst && pk_if.out_valid && pk_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL pop_unexpected: got 0x%0h, expected no word", pk_if.out_data);
        end else begin
          w = exp_q.pop_front();
          check("out_data", 32'(pk_if.out_data), 32'(w.data));
          check("out_partial", 32'(pk_if.out_partial), 32'(w.partial));
        end
      end
    end
  end

  initial begin
    int phase_r;
    pk_if.in_valid  = 1'b0;
    pk_if.in_data   = '0;
    pk_if.flush     = 1'b0;
    pk_if.out_ready = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Basic pack: 0x3 then 0xA gives 0xA3.
    cycle(1'b1, 4'h3, 1'b0, 1'b1);
    cycle(1'b1, 4'hA, 1'b0, 1'b1);
    check("pack_word", 32'(pk_if.out_data), 32'h A3);
    check("pack_partial", 32'(pk_if.out_partial), 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Fill to the brim, then one dropped nibble sets the sticky error.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    check("full_level", 32'(pk_if.fifo_level), 4);
    check("full_in_ready", 32'(pk_if.in_ready), 0);
    check("full_head", 32'(pk_if.out_data), 32'h 21);
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    check("overflow_set", 32'(pk_if.overflow_err), 1);
    // Pop while completing a word: level holds.
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b1);
    check("simul_level", 32'(pk_if.fifo_level), 3);
    repeat (5) cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Flush a lone nibble, then a no-op flush while empty.
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("flush_word", 32'(pk_if.out_data), 32'h 05);
    check("flush_partial", 32'(pk_if.out_partial), 1);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    check("flush_empty_level", 32'(pk_if.fifo_level), 1);
    // Flush alongside the first nibble, then alongside the completing one.
    cycle(1'b1, 4'h6, 1'b1, 1'b0);
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b1, 1'b0);
    check("flush_full_level", 32'(pk_if.fifo_level), 3);
    repeat (4) cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Reset mid-word discards the held nibble.
    cycle(1'b1, 4'hF, 1'b0, 1'b0);
    do_reset(2);
    cycle(1'b1, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 4'h2, 1'b0, 1'b0);
    check("post_reset_word", 32'(pk_if.out_data), 32'h 21);
    cycle(1'b0, 4'h0, 1'b0, 1'b1);

    // Randomised traffic with alternating consumer pressure.
    do_reset(1);
    phase_r = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) phase_r = $urandom_range(0, 100);
      cycle($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 11) == 0,
            $urandom_range(0, 99) < phase_r);
    end
    repeat (12) cycle(1'b0, 4'h0, 1'b0, 1'b1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
